// File: rtl/cache_pkg.sv
// cache_pkg
// Shared cache geometry, the adapter state encoding and the line/word types.
// The cache controller, the data arrays and the memory adapter all import this,
// so the line geometry only has to be changed here.
//   DATA_W         : memory word width in bits
//   WORDS_PER_LINE : words per cache line (power of two)
//   IDX_W          : width of a word index within a line
//   BYTE_W         : byte-offset bits within one word
//   OFF            : byte-offset bits within one line
package cache_pkg;

  localparam int DATA_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);
  localparam int BYTE_W         = $clog2(DATA_W / 8);
  localparam int OFF            = IDX_W + BYTE_W;

  typedef logic [DATA_W-1:0] word_t;

  // Word 0 sits in the least significant bits of the packed line.
  typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cache_mem_adapter_if.sv
// cache_mem_adapter_if
// Single-word req/ack bus between the memory adapter and main memory.
// A word moves at a rising edge where req and ack are both high.
//   req   : word request (master -> slave)
//   we    : 1 = write word, 0 = read word (master -> slave)
//   addr  : word byte address (master -> slave)
//   wdata : write word (master -> slave)
//   ack   : word accepted/completed (slave -> master)
//   rdata : read word, valid with ack (slave -> master)
interface cache_mem_adapter_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  word_t             wdata;
  logic              ack;
  word_t             rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/cache_line_buf.sv
// cache_line_buf
// Word-indexed register holding one cache line.
//   clk       : clock
//   clear     : zero the whole line (highest priority)
//   load      : load the whole line from load_line
//   load_line : line value for load
//   wr_en     : write wr_data into word wr_idx
//   wr_idx    : word index for single-word write
//   wr_data   : word for single-word write
//   rd_idx    : word index for combinational read
//   rd_data   : word at rd_idx
//   line      : full registered line
module cache_line_buf
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  line_t            load_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  word_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            rd_data,
  output line_t            line
);

  always_ff @(posedge clk) begin
    if (clear) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (wr_en) begin
      line[wr_idx] <= wr_data;
    end
  end

  assign rd_data = line[rd_idx];

endmodule

// File: rtl/cache_mem_adapter.sv
// cache_mem_adapter
// Turns line-level writeback/fill pulses from the cache controller into
// WORDS_PER_LINE single-word req/ack transfers on the main-memory bus and
// reports completion with a one-cycle ca_resp pulse.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   mem_read  : fill request pulse
//   mem_write : writeback request pulse
//   line_addr : line address, offset bits ignored
//   wb_line   : writeback line, word 0 in LSBs
//   fill_line : fill line, word 0 in LSBs, held until the next fill starts
//   ca_resp   : one-cycle completion pulse
//   busy      : transfer in progress
//   err       : one-cycle protocol or timeout error pulse
//   bus       : main-memory word bus (master side)
module cache_mem_adapter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [ADDR_W-1:0]          line_addr,
  input  line_t                      wb_line,
  output line_t                      fill_line,
  output logic                       ca_resp,
  output logic                       busy,
  output logic                       err,
  cache_mem_adapter_if.master        bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  adapter_state_t          state;
  logic [ADDR_W-OFF-1:0]   tag;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    last_word;
  logic                    req_any;
  logic                    start_write;
  logic                    start_read;
  logic                    fill_wr;
  word_t                   wb_word;
  word_t                   unused_fill_word;
  line_t                   unused_wb_line;
  logic                    unused_offset;

  assign req_any     = mem_read | mem_write;
  assign start_write = (state == IDLE) && mem_write && !mem_read;
  assign start_read  = (state == IDLE) && mem_read && !mem_write;
  assign idx_nxt     = idx + IDX_W'(1);
  assign last_word   = (idx == IDX_W'(WORDS_PER_LINE - 1));
  assign fill_wr     = (state == READ) && bus.ack;

  // Offset bits of the line address are deliberately dropped.
  assign unused_offset = ^line_addr[OFF-1:0];

  // Writeback copy of the line, so the controller may reuse wb_line at once.
  // The read port looks one word ahead to present the next bus_wdata.
  cache_line_buf u_wb_buf (
    .clk       (clk),
    .clear     (!rst),
    .load      (start_write),
    .load_line (wb_line),
    .wr_en     (1'b0),
    .wr_idx    (idx),
    .wr_data   ('0),
    .rd_idx    (idx_nxt),
    .rd_data   (wb_word),
    .line      (unused_wb_line)
  );

  // Fill line, zeroed when a fill starts so words never received read as 0.
  cache_line_buf u_fill_buf (
    .clk       (clk),
    .clear     (!rst || start_read),
    .load      (1'b0),
    .load_line ('0),
    .wr_en     (fill_wr),
    .wr_idx    (idx),
    .wr_data   (bus.rdata),
    .rd_idx    (idx),
    .rd_data   (unused_fill_word),
    .line      (fill_line)
  );

  // Transfer sequencer. All outputs are registered; ca_resp (and err on a
  // timeout) are raised on the edge that enters RESP so they are high for
  // exactly the RESP cycle. Requests outside IDLE are flagged, never queued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tag       <= '0;
      idx       <= '0;
      tmo_cnt   <= '0;
      ca_resp   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
    end else begin
      ca_resp <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (mem_read && mem_write) begin
            err <= 1'b1;
          end else if (req_any) begin
            tag       <= line_addr[ADDR_W-1:OFF];
            idx       <= '0;
            tmo_cnt   <= '0;
            busy      <= 1'b1;
            bus.req   <= 1'b1;
            bus.we    <= mem_write;
            bus.addr  <= {line_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            bus.wdata <= mem_write ? wb_line[0] : '0;
            state     <= mem_write ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (req_any) begin
            err <= 1'b1;
          end
          if (bus.ack) begin
            tmo_cnt <= '0;
            if (last_word) begin
              bus.req <= 1'b0;
              ca_resp <= 1'b1;
              state   <= RESP;
            end else begin
              idx       <= idx_nxt;
              bus.addr  <= {tag, idx_nxt, {BYTE_W{1'b0}}};
              bus.wdata <= (state == WRITE) ? wb_word : '0;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            bus.req <= 1'b0;
            ca_resp <= 1'b1;
            err     <= 1'b1;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RESP: begin
          if (req_any) begin
            err <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          bus.req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_adapter.sv
// tb_cache_mem_adapter
// Self-checking bench for cache_mem_adapter. A behavioural memory responder
// drives ack/rdata with a programmable latency and logs every handshake into
// obs_q; each test pushes the handshakes it expects into exp_q and compares.
module tb_cache_mem_adapter;
  import cache_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int TIMEOUT_CYC = 64;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          cyc;
  } hs_t;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] line_addr;
  line_t             wb_line;
  line_t             fill_line;
  logic              ca_resp;
  logic              busy;
  logic              err;

  cache_mem_adapter_if #(.ADDR_W(ADDR_W)) bus_if ();

  cache_mem_adapter #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .line_addr (line_addr),
    .wb_line   (wb_line),
    .fill_line (fill_line),
    .ca_resp   (ca_resp),
    .busy      (busy),
    .err       (err),
    .bus       (bus_if)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   cyc_cnt   = 0;
  int   ack_lat   = 0;
  int   stuck_after = 1000;
  int   hs_count  = 0;
  int   wait_cnt  = 0;
  int   stab_viol = 0;
  logic have_prev = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_we;
  hs_t  obs_q[$];
  hs_t  exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Memory responder: decides ack for the coming edge just after each falling
  // edge, logs the handshake that edge will perform, and watches that a
  // pending request holds its address/data until acknowledged.
  initial begin
    bus_if.ack   = 1'b0;
    bus_if.rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bus_if.ack = 1'b0;
      if (rst && bus_if.req) begin
        if (hs_count < stuck_after && wait_cnt >= ack_lat) begin
          bus_if.ack   = 1'b1;
          bus_if.rdata = 32'hA0 + 32'(bus_if.addr[4:2]);
          obs_q.push_back('{addr: bus_if.addr, wdata: bus_if.wdata, we: bus_if.we, cyc: cyc_cnt});
          hs_count++;
          wait_cnt  = 0;
          have_prev = 1'b0;
        end else begin
          if (have_prev && (bus_if.addr !== prev_addr || bus_if.wdata !== prev_wdata || bus_if.we !== prev_we))
            stab_viol++;
          prev_addr  = bus_if.addr;
          prev_wdata = bus_if.wdata;
          prev_we    = bus_if.we;
          have_prev  = 1'b1;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; line_addr = '0; wb_line = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ca_resp, busy, err, bus_if.req, bus_if.we} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=00000", {ca_resp, busy, err, bus_if.req, bus_if.we});
    end
    checks++;
    if (bus_if.addr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_addr got=%h exp=0", bus_if.addr);
    end
    checks++;
    if (bus_if.wdata !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_wdata got=%h exp=0", bus_if.wdata);
    end
    checks++;
    if (fill_line !== '0) begin
      failures++; $display("[TB] FAIL reset_fill got=%h exp=0", fill_line);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_writeback();
    hs_t e, o;
    int resp_cyc = -1, resp_cnt = 0, err_cnt = 0, k = 0, first_cyc = 0;
    obs_q.delete(); exp_q.delete(); hs_count = 0; ack_lat = 0; stab_viol = 0;
    for (int i = 0; i < 8; i++) begin
      wb_line[i] = 32'h11 * (i + 1);
      exp_q.push_back('{addr: 32'h1220 + 32'(4 * i), wdata: 32'h11 * (i + 1), we: 1'b1, cyc: 0});
    end
    line_addr = 32'h0000_1234; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ca_resp) begin resp_cnt++; if (resp_cyc < 0) resp_cyc = c; end
      if (err) err_cnt++;
      @(negedge clk);
    end
    checks++;
    if (resp_cyc != 9 || resp_cnt != 1) begin
      failures++; $display("[TB] FAIL wb_resp got=cyc%0d/n%0d exp=cyc9/n1", resp_cyc, resp_cnt);
    end
    checks++;
    if (err_cnt != 0) begin
      failures++; $display("[TB] FAIL wb_err got=%0d exp=0", err_cnt);
    end
    checks++;
    if (obs_q.size() != 8) begin
      failures++; $display("[TB] FAIL wb_count got=%0d exp=8", obs_q.size());
    end
    if (obs_q.size() > 0) first_cyc = obs_q[0].cyc;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== e.we || o.cyc != first_cyc + k) begin
        failures++;
        $display("[TB] FAIL wb_word%0d got=%h/%h/%b/+%0d exp=%h/%h/%b/+%0d", k,
                 o.addr, o.wdata, o.we, o.cyc - first_cyc, e.addr, e.wdata, e.we, k);
      end
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL wb_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_fill();
    hs_t e, o;
    int resp_abs = -1, resp_cnt = 0, err_cnt = 0, last_cyc = -100, k = 0;
    obs_q.delete(); exp_q.delete(); hs_count = 0; ack_lat = 2; stab_viol = 0;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{addr: 32'h2000 + 32'(4 * i), wdata: 32'h0, we: 1'b0, cyc: 0});
    line_addr = 32'h0000_2000; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (ca_resp) begin resp_cnt++; if (resp_abs < 0) resp_abs = cyc_cnt; end
      if (err) err_cnt++;
      @(negedge clk);
    end
    if (obs_q.size() > 0) last_cyc = obs_q[obs_q.size() - 1].cyc;
    checks++;
    if (resp_cnt != 1 || resp_abs != last_cyc + 1) begin
      failures++; $display("[TB] FAIL fill_resp got=n%0d@%0d exp=n1@%0d", resp_cnt, resp_abs, last_cyc + 1);
    end
    checks++;
    if (err_cnt != 0) begin
      failures++; $display("[TB] FAIL fill_err got=%0d exp=0", err_cnt);
    end
    checks++;
    if (stab_viol != 0) begin
      failures++; $display("[TB] FAIL fill_hold got=%0d exp=0", stab_viol);
    end
    checks++;
    if (obs_q.size() != 8) begin
      failures++; $display("[TB] FAIL fill_count got=%0d exp=8", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.we !== e.we) begin
        failures++; $display("[TB] FAIL fill_addr%0d got=%h/%b exp=%h/%b", k, o.addr, o.we, e.addr, e.we);
      end
      k++;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fill_line[i] !== 32'hA0 + 32'(i)) begin
        failures++; $display("[TB] FAIL fill_word%0d got=%h exp=%h", i, fill_line[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_timeout();
    int req_cnt = 0, resp_cyc = -1, resp_cnt = 0, err_cnt = 0;
    logic err_at_resp = 1'b0;
    obs_q.delete(); hs_count = 0; ack_lat = 0; stuck_after = 3; stab_viol = 0;
    line_addr = 32'h0000_3000; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (bus_if.req) req_cnt++;
      if (ca_resp) begin resp_cnt++; if (resp_cyc < 0) begin resp_cyc = c; err_at_resp = err; end end
      if (err) err_cnt++;
      @(negedge clk);
    end
    stuck_after = 1000;
    checks++;
    if (req_cnt != 3 + TIMEOUT_CYC) begin
      failures++; $display("[TB] FAIL tmo_req_len got=%0d exp=%0d", req_cnt, 3 + TIMEOUT_CYC);
    end
    checks++;
    if (resp_cnt != 1 || resp_cyc != 4 + TIMEOUT_CYC || err_at_resp !== 1'b1 || err_cnt != 1) begin
      failures++;
      $display("[TB] FAIL tmo_resp got=n%0d@%0d err=%b/%0d exp=n1@%0d err=1/1",
               resp_cnt, resp_cyc, err_at_resp, err_cnt, 4 + TIMEOUT_CYC);
    end
    checks++;
    if (stab_viol != 0) begin
      failures++; $display("[TB] FAIL tmo_hold got=%0d exp=0", stab_viol);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fill_line[i] !== ((i < 3) ? 32'hA0 + 32'(i) : 32'h0)) begin
        failures++;
        $display("[TB] FAIL tmo_word%0d got=%h exp=%h", i, fill_line[i], (i < 3) ? 32'hA0 + 32'(i) : 32'h0);
      end
    end
  endtask

  task automatic test_protocol();
    hs_t e, o;
    int resp_cnt = 0, err_cnt = 0, k = 0;
    obs_q.delete(); exp_q.delete(); hs_count = 0; ack_lat = 0;
    line_addr = 32'h0000_7000; mem_read = 1'b1; mem_write = 1'b1;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    checks++;
    if (err !== 1'b1 || bus_if.req !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL both_req got=err%b req%b busy%b exp=err1 req0 busy0", err, bus_if.req, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || bus_if.req !== 1'b0) begin
      failures++; $display("[TB] FAIL both_req_after got=err%b req%b exp=err0 req0", err, bus_if.req);
    end
    ack_lat = 1;
    for (int i = 0; i < 8; i++) begin
      wb_line[i] = 32'hC000_0000 + 32'(3 * i);
      exp_q.push_back('{addr: 32'h4000 + 32'(4 * i), wdata: 32'hC000_0000 + 32'(3 * i), we: 1'b1, cyc: 0});
    end
    line_addr = 32'h0000_4000; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        checks++;
        if (err !== 1'b1) begin
          failures++; $display("[TB] FAIL busy_req_err got=%b exp=1", err);
        end
      end
      if (err) err_cnt++;
      if (ca_resp) resp_cnt++;
      mem_read = (c == 4);
      @(negedge clk);
    end
    mem_read = 1'b0;
    checks++;
    if (resp_cnt != 1 || err_cnt != 1) begin
      failures++; $display("[TB] FAIL busy_req_resp got=n%0d err%0d exp=n1 err1", resp_cnt, err_cnt);
    end
    checks++;
    if (obs_q.size() != 8) begin
      failures++; $display("[TB] FAIL busy_req_count got=%0d exp=8", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== e.we) begin
        failures++; $display("[TB] FAIL busy_req_word%0d got=%h/%h/%b exp=%h/%h/%b", k,
                             o.addr, o.wdata, o.we, e.addr, e.wdata, e.we);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    hs_t e, o;
    int resp_cnt = 0, resp_cyc = -1, k = 0;
    obs_q.delete(); exp_q.delete(); hs_count = 0; ack_lat = 0;
    line_addr = 32'h0000_5000; mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (hs_count != 5) begin
      failures++; $display("[TB] FAIL rstmid_pre got=%0d exp=5", hs_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ca_resp, busy, err, bus_if.req, bus_if.we} !== 5'b0 || bus_if.addr !== 32'h0 ||
        bus_if.wdata !== 32'h0 || fill_line !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_outs got=%b/%h/%h/%h exp=00000/0/0/0",
               {ca_resp, busy, err, bus_if.req, bus_if.we}, bus_if.addr, bus_if.wdata, fill_line);
    end
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (ca_resp) resp_cnt++;
      @(negedge clk);
    end
    checks++;
    if (resp_cnt != 0 || hs_count != 5) begin
      failures++; $display("[TB] FAIL rstmid_noresp got=n%0d hs%0d exp=n0 hs5", resp_cnt, hs_count);
    end
    obs_q.delete(); hs_count = 0; resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wb_line[i] = 32'h600 + 32'(i);
      exp_q.push_back('{addr: 32'h6000 + 32'(4 * i), wdata: 32'h600 + 32'(i), we: 1'b1, cyc: 0});
    end
    line_addr = 32'h0000_6000; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ca_resp) begin resp_cnt++; if (resp_cyc < 0) resp_cyc = c; end
      @(negedge clk);
    end
    checks++;
    if (resp_cyc != 9 || resp_cnt != 1 || obs_q.size() != 8) begin
      failures++; $display("[TB] FAIL rstmid_after got=cyc%0d/n%0d/hs%0d exp=cyc9/n1/hs8", resp_cyc, resp_cnt, obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== e.we) begin
        failures++; $display("[TB] FAIL rstmid_word%0d got=%h/%h/%b exp=%h/%h/%b", k,
                             o.addr, o.wdata, o.we, e.addr, e.wdata, e.we);
      end
      k++;
    end
  endtask

  initial begin
    $display("[TB] cache_mem_adapter bench start");
    test_reset();
    test_writeback();
    test_fill();
    test_timeout();
    test_protocol();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
